// File: rtl/reg_file_pkg.sv
// Shared types and default sizes for the multi-port register file.
package reg_file_pkg;

    typedef enum logic {
        IDLE     = 1'b0,
        CLEARING = 1'b1
    } state_t;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_ADDR_W = 3;

endpackage

// File: rtl/reg_file_clear_seq.sv
// Hardware clear sequencer: steps one register address per cycle while BUSY.
module reg_file_clear_seq
    import reg_file_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              CLEAR,
    output logic              BUSY,
    output logic              clr_en,
    output logic [ADDR_W-1:0] clr_addr
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // CLEAR is only honoured from IDLE, so a request mid-sweep cannot restart it.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        clr_en  = 1'b0;
        case (state_q)
            IDLE: begin
                if (CLEAR) begin
                    state_d = CLEARING;
                    cnt_d   = '0;
                end
            end
            CLEARING: begin
                clr_en = 1'b1;
                if (cnt_q == LAST_ADDR) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign BUSY     = (state_q == CLEARING);
    assign clr_addr = cnt_q;

endmodule

// File: rtl/reg_file_mp.sv
// Register file: 1 sync write, 2 async reads, optional zero register and clear sweep.
// Define REG_FILE_BYPASS_EN to forward an accepted write to matching read ports.
module reg_file_mp
    import reg_file_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter bit ZERO_REG = 1'b0
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [DATA_W-1:0] IN,
    input  logic [ADDR_W-1:0] INADDRESS,
    input  logic              WRITE,
    input  logic [ADDR_W-1:0] OUT1ADDRESS,
    input  logic [ADDR_W-1:0] OUT2ADDRESS,
    output logic [DATA_W-1:0] OUT1,
    output logic [DATA_W-1:0] OUT2,
    input  logic              CLEAR,
    output logic              BUSY,
    output logic              WR_DROP
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DATA_W-1:0] regs_d [DEPTH];
    logic              clr_en;
    logic [ADDR_W-1:0] clr_addr;
    logic              wr_zero;
    logic              wr_acc;

    reg_file_clear_seq #(
        .ADDR_W (ADDR_W)
    ) u_clear_seq (
        .CLK      (CLK),
        .RESET    (RESET),
        .CLEAR    (CLEAR),
        .BUSY     (BUSY),
        .clr_en   (clr_en),
        .clr_addr (clr_addr)
    );

    // A zero-register write is silently absorbed; it is not reported as a drop.
    assign wr_zero = ZERO_REG && (INADDRESS == '0);
    assign wr_acc  = WRITE && !BUSY && !wr_zero;
    assign WR_DROP = WRITE && BUSY;

    always_comb begin
        regs_d = regs_q;
        if (wr_acc) begin
            regs_d[INADDRESS] = IN;
        end
        if (clr_en) begin
            regs_d[clr_addr] = '0;
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    always_comb begin
        OUT1 = regs_q[OUT1ADDRESS];
        OUT2 = regs_q[OUT2ADDRESS];
`ifdef REG_FILE_BYPASS_EN
        if (wr_acc && (INADDRESS == OUT1ADDRESS)) begin
            OUT1 = IN;
        end
        if (wr_acc && (INADDRESS == OUT2ADDRESS)) begin
            OUT2 = IN;
        end
`endif
        if (ZERO_REG && (OUT1ADDRESS == '0)) begin
            OUT1 = '0;
        end
        if (ZERO_REG && (OUT2ADDRESS == '0)) begin
            OUT2 = '0;
        end
    end

endmodule

// File: tb/tb_reg_file_mp.sv
// Bench for reg_file_mp: directed plan steps plus random traffic against an array model.
module tb_reg_file_mp;

    localparam int DEPTH = 8;

    logic       CLK = 1'b0;
    logic       RESET = 1'b0;
    logic [7:0] IN = '0;
    logic [2:0] INADDRESS = '0;
    logic       WRITE = 1'b0;
    logic [2:0] OUT1ADDRESS = '0;
    logic [2:0] OUT2ADDRESS = '0;
    logic       CLEAR = 1'b0;

    logic [7:0] o1_a, o2_a, o1_b, o2_b;
    logic       busy_a, busy_b, drop_a, drop_b;

    int tests = 0;
    int fails = 0;

    // Reference state: plain arrays plus a remaining-sweep position.
    logic [7:0] m0 [DEPTH];
    logic [7:0] m1 [DEPTH];
    bit         mbusy = 1'b0;
    int         midx  = 0;

    always #5 CLK = ~CLK;

    reg_file_mp #(.DATA_W(8), .ADDR_W(3), .ZERO_REG(1'b0)) dut_a (
        .CLK(CLK), .RESET(RESET), .IN(IN), .INADDRESS(INADDRESS), .WRITE(WRITE),
        .OUT1ADDRESS(OUT1ADDRESS), .OUT2ADDRESS(OUT2ADDRESS), .OUT1(o1_a), .OUT2(o2_a),
        .CLEAR(CLEAR), .BUSY(busy_a), .WR_DROP(drop_a)
    );

    reg_file_mp #(.DATA_W(8), .ADDR_W(3), .ZERO_REG(1'b1)) dut_b (
        .CLK(CLK), .RESET(RESET), .IN(IN), .INADDRESS(INADDRESS), .WRITE(WRITE),
        .OUT1ADDRESS(OUT1ADDRESS), .OUT2ADDRESS(OUT2ADDRESS), .OUT1(o1_b), .OUT2(o2_b),
        .CLEAR(CLEAR), .BUSY(busy_b), .WR_DROP(drop_b)
    );

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) begin
            m0[i] = '0;
            m1[i] = '0;
        end
        mbusy = 1'b0;
        midx  = 0;
    endtask

    task automatic model_edge();
        if (mbusy) begin
            m0[midx] = '0;
            m1[midx] = '0;
            midx++;
            if (midx == DEPTH) begin
                mbusy = 1'b0;
                midx  = 0;
            end
        end else begin
            if (WRITE) begin
                m0[INADDRESS] = IN;
                if (INADDRESS != 3'd0) m1[INADDRESS] = IN;
            end
            if (CLEAR) begin
                mbusy = 1'b1;
                midx  = 0;
            end
        end
    endtask

    function automatic logic [7:0] exp_rd(bit zr, logic [2:0] a);
        if (zr && a == 3'd0) return 8'h00;
`ifdef REG_FILE_BYPASS_EN
        if (WRITE && !mbusy && a == INADDRESS) return IN;
`endif
        return zr ? m1[a] : m0[a];
    endfunction

    task automatic chk(string tag, logic [7:0] obs, logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all(string tag);
        #1;
        chk({tag, ".a.out1"}, o1_a, exp_rd(1'b0, OUT1ADDRESS));
        chk({tag, ".a.out2"}, o2_a, exp_rd(1'b0, OUT2ADDRESS));
        chk({tag, ".b.out1"}, o1_b, exp_rd(1'b1, OUT1ADDRESS));
        chk({tag, ".b.out2"}, o2_b, exp_rd(1'b1, OUT2ADDRESS));
        chk({tag, ".a.busy"}, {7'd0, busy_a}, {7'd0, mbusy});
        chk({tag, ".b.busy"}, {7'd0, busy_b}, {7'd0, mbusy});
        chk({tag, ".a.drop"}, {7'd0, drop_a}, {7'd0, WRITE && mbusy});
        chk({tag, ".b.drop"}, {7'd0, drop_b}, {7'd0, WRITE && mbusy});
    endtask

    task automatic step();
        @(posedge CLK);
        model_edge();
        #1;
    endtask

    // Starting from the first BUSY cycle, run until idle and count high cycles.
    task automatic sweep(input int drop_at, input int reclr_at, output int n);
        n = 0;
        for (int k = 0; k < 16; k++) begin
            WRITE       = (k == drop_at);
            INADDRESS   = 3'd2;
            IN          = 8'hFF;
            CLEAR       = (k == reclr_at);
            OUT1ADDRESS = 3'(k);
            OUT2ADDRESS = 3'd7;
            check_all("sweep");
            if (busy_a) n++;
            step();
        end
        WRITE = 1'b0;
        CLEAR = 1'b0;
    endtask

    initial begin
        int n;
        model_reset();

        // Reset held
        #12;
        check_all("reset");
        RESET = 1'b1;

        // Plan 1: every address reads zero after reset
        for (int a = 0; a < DEPTH; a++) begin
            step();
            OUT1ADDRESS = 3'(a);
            OUT2ADDRESS = 3'(7 - a);
            check_all("rst_read");
        end

        // Plan 2: write then read, same address on both ports
        WRITE = 1'b1; INADDRESS = 3'd3; IN = 8'hA5; OUT1ADDRESS = 3'd3;
        check_all("wr_a5");
        step();
        INADDRESS = 3'd5; IN = 8'h3C;
        step();
        WRITE = 1'b0; OUT1ADDRESS = 3'd3; OUT2ADDRESS = 3'd5;
        check_all("rd_35");
        chk("direct.r3", o1_a, 8'hA5);
        chk("direct.r5", o2_a, 8'h3C);
        OUT2ADDRESS = 3'd3;
        check_all("same_addr");
        chk("same_addr.eq", o2_a, o1_a);

        // Plan 3: fill, clear with mid-sweep write and re-clear
        for (int i = 0; i < DEPTH; i++) begin
            WRITE = 1'b1; INADDRESS = 3'(i); IN = 8'(8'h11 * (i + 1));
            step();
        end
        WRITE = 1'b0; OUT1ADDRESS = 3'd7;
        check_all("filled");
        chk("direct.r7", o1_a, 8'h88);
        CLEAR = 1'b1;
        step();
        CLEAR = 1'b0;
        sweep(3, 5, n);
        chk("busy_len", 8'(n), 8'd8);
        OUT1ADDRESS = 3'd2; OUT2ADDRESS = 3'd7;
        check_all("post_clear");
        chk("direct.r2", o1_a, 8'h00);

        // Simultaneous write and clear: write lands, sweep wipes it
        WRITE = 1'b1; CLEAR = 1'b1; INADDRESS = 3'd6; IN = 8'h6D;
        step();
        sweep(-1, -1, n);
        chk("busy_len2", 8'(n), 8'd8);

        // Plan 4: zero register
        WRITE = 1'b1; INADDRESS = 3'd0; IN = 8'h55;
        step();
        INADDRESS = 3'd1; IN = 8'h66;
        step();
        WRITE = 1'b0; OUT1ADDRESS = 3'd0; OUT2ADDRESS = 3'd1;
        check_all("zero_reg");
        chk("direct.zr0", o1_b, 8'h00);
        chk("direct.zr1", o2_b, 8'h66);
        chk("direct.nz0", o1_a, 8'h55);

        // Plan 5: forwarding (or not) of a pending write
        WRITE = 1'b1; INADDRESS = 3'd4; IN = 8'h7E; OUT1ADDRESS = 3'd4;
        check_all("bypass_pre");
`ifdef REG_FILE_BYPASS_EN
        chk("direct.bypass", o1_a, 8'h7E);
`else
        chk("direct.nobypass", o1_a, 8'h00);
`endif
        step();
        WRITE = 1'b0;
        check_all("bypass_post");
        chk("direct.r4", o1_a, 8'h7E);

        // Plan 6: async reset during a sweep, then a full sweep again
        CLEAR = 1'b1;
        step();
        CLEAR = 1'b0;
        step();
        step();
        #1;
        RESET = 1'b0;
        model_reset();
        OUT1ADDRESS = 3'd5; OUT2ADDRESS = 3'd4;
        check_all("async_rst");
        chk("direct.rst_busy", {7'd0, busy_a}, 8'd0);
        RESET = 1'b1;
        CLEAR = 1'b1;
        step();
        CLEAR = 1'b0;
        sweep(-1, -1, n);
        chk("busy_len3", 8'(n), 8'd8);

        // Random traffic
        for (int c = 0; c < 400; c++) begin
            WRITE       = ($urandom_range(0, 1) == 1);
            CLEAR       = ($urandom_range(0, 19) == 0);
            IN          = 8'($urandom);
            INADDRESS   = 3'($urandom);
            OUT1ADDRESS = 3'($urandom);
            OUT2ADDRESS = ($urandom_range(0, 3) == 0) ? INADDRESS : 3'($urandom);
            check_all("rand");
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
